sm_move_ctrl: RTL
=================

SM_MOVE_CTRL -- requirements
Module: sm_move_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 16, width of step count and period fields.
REQ-002 SHALL have parameter MIN_PERIOD, default 8, smallest legal step period in clk cycles.
REQ-003 SHALL have parameter SETTLE, default 10, direction-setup cycles before enabling pulses.
REQ-004 SHALL have port clk  input  1  system clock, 50 MHz.
REQ-005 SHALL have port rst  input  1  reset; one clock, synchronous, active-high.
REQ-006 SHALL have port cmd_valid  input  1  move command offered.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready.
REQ-008 SHALL have port cmd_auto  input  1  1 = continuous move until stop_req; 0 = move cmd_steps.
REQ-009 SHALL have port cmd_dir  input  1  rotation direction.
REQ-010 SHALL have port cmd_steps  input  SIZE  step count for a counted move.
REQ-011 SHALL have port cmd_period  input  SIZE  step period in clk cycles.
REQ-012 SHALL have port stop_req  input  1  abort current move.
REQ-013 SHALL have port drv_step  input  1  step pulse fed back from the pulse generator.
REQ-014 SHALL have port drv_en_SM  output  1  pulse generator enable.
REQ-015 SHALL have port drv_dir  output  1  direction to motor driver.
REQ-016 SHALL have port n  output  SIZE  period to pulse generator.
REQ-017 SHALL have port busy  output  1  move in progress.
REQ-018 SHALL have port done  output  1  one-cycle end-of-move strobe.
REQ-019 SHALL have port aborted  output  1  last move ended by stop_req; held until next accept.
REQ-020 SHALL have port steps_done  output  SIZE  rising edges of drv_step counted in current/last move.

Function
REQ-021 States SHALL be IDLE, SETUP, MOVE, DRAIN, DONE; cmd_ready=1 only in IDLE.
REQ-022 On accept in IDLE: latch dir, auto, steps, period; clear steps_done and aborted; go SETUP.
REQ-023 Latched period < MIN_PERIOD SHALL be clamped to MIN_PERIOD; n SHALL drive the latched value from SETUP entry.
REQ-024 Counted command with cmd_steps=0 SHALL go IDLE->DONE directly, drv_en_SM never asserted.
REQ-025 SETUP SHALL hold drv_dir stable, drv_en_SM=0, for exactly SETTLE cycles, then go MOVE.
REQ-026 MOVE SHALL assert drv_en_SM; steps_done SHALL increment one cycle after each 0->1 of drv_step; edge detector cleared on SETUP entry.
REQ-027 Counted move: when steps_done reaches latched steps, drop drv_en_SM next cycle, go DRAIN.
REQ-028 stop_req in SETUP or MOVE SHALL set aborted, drop drv_en_SM next cycle, go DRAIN; in auto mode this is the only exit.
REQ-029 stop_req in the same cycle the final counted edge is registered SHALL count as normal completion, aborted=0.
REQ-030 DRAIN SHALL wait until drv_step=0, then go DONE; edges seen in DRAIN are not counted.
REQ-031 DONE SHALL assert done for one cycle, then go IDLE; busy=1 in SETUP, MOVE, DRAIN, DONE.
REQ-032 steps_done SHALL saturate at all-ones in auto mode, no wrap.
REQ-033 stop_req in IDLE or DONE SHALL be ignored; cmd_valid outside IDLE SHALL be ignored, not queued.
REQ-034 drv_dir SHALL change only on command accept.

Reset
REQ-035 rst SHALL force IDLE; cmd_ready=0 during rst then 1; drv_en_SM, drv_dir, busy, done, aborted=0; n, steps_done=0.
REQ-036 rst mid-move SHALL drop drv_en_SM on the next edge, no done strobe.

Structure
REQ-037 State encoding, MIN_PERIOD and SETTLE defaults SHALL live in shared package sm_ctrl_pkg.
REQ-038 Edge detection plus saturating counter SHALL be one sub-module sm_step_counter; FSM stays in sm_move_ctrl.

Verification
REQ-039 Counted: steps=5, period=20, bench pulse generator -> 5 edges, drv_en_SM falls after 5th, done once, steps_done=5, aborted=0.
REQ-040 Zero steps: steps=0 -> done 1 cycle after accept, drv_en_SM never 1, steps_done=0.
REQ-041 Clamp: period=3 -> n=8 during move.
REQ-042 Auto: auto=1, stop_req after 7 edges -> steps_done=7, aborted=1, done after drv_step low.
REQ-043 Race: stop_req coincident with 5th registered edge of steps=5 -> aborted=0, steps_done=5.
REQ-044 rst during MOVE after 3 edges -> drv_en_SM=0 next cycle, IDLE, steps_done=0, no done.

Source files
------------

// File: rtl/sm_ctrl_pkg.sv
// Shared constants for the stepper move controller: FSM encoding and
// default timing parameters.
package sm_ctrl_pkg;

    localparam int MIN_PERIOD_DEF = 8;
    localparam int SETTLE_DEF     = 10;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_MOVE  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/sm_step_counter.sv
// Rising-edge detector on the step feedback plus a saturating step counter.
// clr_i restarts both the edge history and the count for a new move.
module sm_step_counter #(
    parameter int SIZE = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic            step_i,
    output logic            rise_o,
    output logic [SIZE-1:0] count_o
);

    logic            step_q;
    logic [SIZE-1:0] count_q;

    assign rise_o  = step_i && !step_q;
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            step_q  <= 1'b0;
            count_q <= '0;
        end else begin
            step_q <= step_i;
            // Hold at all-ones rather than wrapping on very long auto moves.
            if (en_i && rise_o && (count_q != '1))
                count_q <= count_q + SIZE'(1);
        end
    end

endmodule

// File: rtl/sm_move_ctrl.sv
// Stepper move controller: accepts a counted or continuous move, sequences
// direction setup, pulse enable, drain of the last pulse and a done strobe.
module sm_move_ctrl #(
    parameter int SIZE       = 16,
    parameter int MIN_PERIOD = sm_ctrl_pkg::MIN_PERIOD_DEF,
    parameter int SETTLE     = sm_ctrl_pkg::SETTLE_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_auto,
    input  logic            cmd_dir,
    input  logic [SIZE-1:0] cmd_steps,
    input  logic [SIZE-1:0] cmd_period,
    input  logic            stop_req,
    input  logic            drv_step,
    output logic            drv_en_SM,
    output logic            drv_dir,
    output logic [SIZE-1:0] n,
    output logic            busy,
    output logic            done,
    output logic            aborted,
    output logic [SIZE-1:0] steps_done
);
    import sm_ctrl_pkg::*;

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [2:0]      state_q, state_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic            aborted_q, aborted_d;
    logic            dir_q, auto_q;
    logic [SIZE-1:0] steps_q, period_q, period_in, count;
    logic            rise, accept, reached, last_edge, cnt_en;

    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign period_in = (cmd_period < SIZE'(MIN_PERIOD)) ? SIZE'(MIN_PERIOD) : cmd_period;

    assign reached   = !auto_q && (count == steps_q);
    // The final counted edge wins over a simultaneous stop.
    assign last_edge = !auto_q && rise && (count == steps_q - SIZE'(1));
    assign cnt_en    = (state_q == ST_MOVE) && !reached;

    sm_step_counter #(.SIZE(SIZE)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (accept),
        .en_i    (cnt_en),
        .step_i  (drv_step),
        .rise_o  (rise),
        .count_o (count)
    );

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        aborted_d = aborted_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    aborted_d = 1'b0;
                    settle_d  = '0;
                    state_d   = (!cmd_auto && (cmd_steps == '0)) ? ST_DONE : ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (stop_req) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DRAIN;
                end else if (settle_q == SW'(SETTLE - 1)) begin
                    state_d = ST_MOVE;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            ST_MOVE: begin
                if (reached) begin
                    state_d = ST_DRAIN;
                end else if (stop_req && !last_edge) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!drv_step)
                    state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            settle_q  <= '0;
            aborted_q <= 1'b0;
            dir_q     <= 1'b0;
            auto_q    <= 1'b0;
            steps_q   <= '0;
            period_q  <= '0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            aborted_q <= aborted_d;
            if (accept) begin
                dir_q    <= cmd_dir;
                auto_q   <= cmd_auto;
                steps_q  <= cmd_steps;
                period_q <= period_in;
            end
        end
    end

    assign drv_en_SM  = (state_q == ST_MOVE);
    assign drv_dir    = dir_q;
    assign n          = period_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign aborted    = aborted_q;
    assign steps_done = count;

endmodule
